brch_pred_resolve_queue: RTL and testbench

Tracks every branch prediction issued at fetch until the branch resolves in EX. It then drives the update port of the local prediction table: `upd_pred_state`, `lpt_addr` and `actual_brch_result`. It also flags mispredictions and supplies the redirect PC. The block sits between fetch (push side), the EX branch unit (resolve side) and the 32-entry 2-bit-counter local prediction table (update side).

---
 rtl/brch_pred_pkg.sv | 24 ++
 rtl/brch_pred_stats.sv | 35 +++
 rtl/brch_pred_resolve_queue.sv | 146 ++++++++++++++
 tb/tb_brch_pred_resolve_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brch_pred_pkg.sv
// Shared types for the branch prediction resolve queue:
// LPT counter encodings, queue entry layout and output FSM states.
package brch_pred_pkg;

  localparam int BPQ_ADDR_W = 5;

  localparam logic [1:0] LPT_STRONG_T  = 2'b11;
  localparam logic [1:0] LPT_WEAK_T    = 2'b10;
  localparam logic [1:0] LPT_WEAK_NT   = 2'b01;
  localparam logic [1:0] LPT_STRONG_NT = 2'b00;

  typedef struct packed {
    logic [BPQ_ADDR_W-1:0] lpt_addr;
    logic                  pred_taken;
    logic [31:0]           fallthru_pc;
  } bpq_entry_t;

  typedef enum logic [1:0] {
    BPQ_IDLE,
    BPQ_UPD,
    BPQ_UPD_MISP
  } bpq_state_e;

endpackage

// File: rtl/brch_pred_stats.sv
// Saturating resolve / mispredict counters for the resolve queue.
// Only built when BPQ_STATS_EN is defined.
module brch_pred_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_pred_state,
  input  logic        mispredict,
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_mispred
);

  logic [15:0] res_q, res_d;
  logic [15:0] mis_q, mis_d;

  always_comb begin
    res_d = res_q;
    mis_d = mis_q;
    if (upd_pred_state && res_q != 16'hFFFF) res_d = res_q + 16'd1;
    if (mispredict && mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      mis_q <= '0;
    end else begin
      res_q <= res_d;
      mis_q <= mis_d;
    end
  end

  assign stat_resolved = res_q;
  assign stat_mispred  = mis_q;

endmodule

// File: rtl/brch_pred_resolve_queue.sv
// In-flight branch queue: fetch pushes predictions, EX resolves them,
// driving LPT updates and redirects. BPQ_STATS_EN adds stat counters.
module brch_pred_resolve_queue
  import brch_pred_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BPQ_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_lpt_addr,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_fallthru_pc,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     upd_pred_state,
  output logic [ADDR_W-1:0]        lpt_addr,
  output logic                     actual_brch_result,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic                     underflow_err
`ifdef BPQ_STATS_EN
  ,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bpq_entry_t mem_q [DEPTH];
  bpq_entry_t head_e;
  bpq_entry_t push_e;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              flush_q, flush_d;
  logic              under_q, under_d;
  bpq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              act_q, act_d;
  logic [31:0]       rpc_q, rpc_d;

  logic pop;
  logic mis;
  logic push;

  always_comb begin
    head_e = mem_q[head_q];
    push_e = '{lpt_addr:    pred_lpt_addr,
               pred_taken:  pred_taken,
               fallthru_pc: pred_fallthru_pc};
    pop  = res_valid && (count_q != '0);
    mis  = pop && (res_taken != head_e.pred_taken);
    // wrong-path fetches during the flush window are dropped
    push = pred_valid && (!full_q || pop) && !mis && !flush_q;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) head_d = head_q + PW'(1);
    if (mis) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      unique case (1'b1)
        push && !pop: count_d = count_q + CW'(1);
        pop && !push: count_d = count_q - CW'(1);
        default:      count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    flush_d = mis;
    under_d = under_q | (res_valid && (count_q == '0));

    state_d = BPQ_IDLE;
    addr_d  = '0;
    act_d   = 1'b0;
    rpc_d   = '0;
    if (pop) begin
      state_d = mis ? BPQ_UPD_MISP : BPQ_UPD;
      addr_d  = head_e.lpt_addr;
      act_d   = res_taken;
      if (mis) rpc_d = res_taken ? res_target : head_e.fallthru_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[tail_q] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      flush_q <= 1'b0;
      under_q <= 1'b0;
      state_q <= BPQ_IDLE;
      addr_q  <= '0;
      act_q   <= 1'b0;
      rpc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      flush_q <= flush_d;
      under_q <= under_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      rpc_q   <= rpc_d;
    end
  end

  assign full               = full_q;
  assign count              = count_q;
  assign upd_pred_state     = (state_q != BPQ_IDLE);
  assign mispredict         = (state_q == BPQ_UPD_MISP);
  assign lpt_addr           = addr_q;
  assign actual_brch_result = act_q;
  assign redirect_pc        = rpc_q;
  assign underflow_err      = under_q;

`ifdef BPQ_STATS_EN
  brch_pred_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .upd_pred_state (upd_pred_state),
    .mispredict     (mispredict),
    .stat_resolved  (stat_resolved),
    .stat_mispred   (stat_mispred)
  );
`endif

endmodule

// File: tb/tb_brch_pred_resolve_queue.sv
// Scoreboard bench for brch_pred_resolve_queue (DEPTH=4, ADDR_W=5).
// Stat counter checks compile in when BPQ_STATS_EN is defined.
module tb_brch_pred_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [4:0]  pred_lpt_addr;
  logic        pred_taken;
  logic [31:0] pred_fallthru_pc;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        full;
  logic [2:0]  count;
  logic        upd_pred_state;
  logic [4:0]  lpt_addr;
  logic        actual_brch_result;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        underflow_err;
`ifdef BPQ_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
`endif

  brch_pred_resolve_queue #(.DEPTH(4), .ADDR_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .pred_valid         (pred_valid),
    .pred_lpt_addr      (pred_lpt_addr),
    .pred_taken         (pred_taken),
    .pred_fallthru_pc   (pred_fallthru_pc),
    .res_valid          (res_valid),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .full               (full),
    .count              (count),
    .upd_pred_state     (upd_pred_state),
    .lpt_addr           (lpt_addr),
    .actual_brch_result (actual_brch_result),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc),
    .underflow_err      (underflow_err)
`ifdef BPQ_STATS_EN
    ,
    .stat_resolved      (stat_resolved),
    .stat_mispred       (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic        taken;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic        act;
    logic        misp;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        pv;
    logic [4:0]  a;
    logic        pt;
    logic [31:0] fpc;
    logic        rv;
    logic        rt;
    logic [31:0] tgt;
  } stim_t;

  ent_t mq[$];
  exp_t sb[$];
  exp_t e;
  logic mflush;
  logic munder;
  int   mres;
  int   mmis;
  int   vec  = 0;
  int   errs = 0;

  function automatic stim_t mk(input logic pv, input logic [4:0] a,
                               input logic pt, input logic [31:0] fpc,
                               input logic rv, input logic rt,
                               input logic [31:0] tgt);
    stim_t s;
    s = '{pv, a, pt, fpc, rv, rt, tgt};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ent_t h;
    exp_t x;
    logic pop;
    logic mis;
    logic push;
    pop  = s.rv && (mq.size() > 0);
    mis  = 1'b0;
    push = s.pv && ((mq.size() < 4) || pop) && !mflush;
    if (s.rv && mq.size() == 0) munder = 1'b1;
    if (pop) begin
      h      = mq.pop_front();
      mis    = (s.rt != h.taken);
      x.addr = h.addr;
      x.act  = s.rt;
      x.misp = mis;
      x.pc   = s.rt ? s.tgt : h.pc;
      sb.push_back(x);
      mres++;
      if (mis) mmis++;
    end
    if (mis) mq.delete();
    else if (push) mq.push_back('{s.a, s.pt, s.fpc});
    pred_valid       = s.pv;
    pred_lpt_addr    = s.a;
    pred_taken       = s.pt;
    pred_fallthru_pc = s.fpc;
    res_valid        = s.rv;
    res_taken        = s.rt;
    res_target       = s.tgt;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    mflush     = mis;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    sb.delete();
    mflush = 1'b0;
    munder = 1'b0;
    mres   = 0;
    mmis   = 0;
  endtask

  task automatic test_reset();
    pred_lpt_addr    = '0;
    pred_taken       = 1'b0;
    pred_fallthru_pc = '0;
    res_taken        = 1'b0;
    res_target       = '0;
    do_reset();
    vec++;
    if ({full, count, upd_pred_state, lpt_addr, actual_brch_result,
         mispredict, redirect_pc, underflow_err} !== '0) begin
      errs++;
      $display("FAIL reset: got full=%0b count=%0d upd=%0b addr=%0d act=%0b misp=%0b pc=%h uf=%0b need all 0",
               full, count, upd_pred_state, lpt_addr, actual_brch_result,
               mispredict, redirect_pc, underflow_err);
    end
  endtask

  task automatic test_match();
    stim_t st[$];
    do_reset();
    st.push_back(mk(1, 5'd5, 1, 32'h44, 0, 0, 0));
    st.push_back(mk(0, 5'd0, 0, 32'h0,  1, 1, 32'h80));
    st.push_back(mk(0, 5'd0, 0, 32'h0,  0, 0, 0));
    st.push_back(mk(1, 5'd3, 0, 32'h100, 0, 0, 0));
    st.push_back(mk(0, 5'd0, 0, 32'h0,  1, 1, 32'h200));
    st.push_back(mk(0, 5'd0, 0, 32'h0,  0, 0, 0));
    st.push_back(mk(0, 5'd0, 0, 32'h0,  0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      vec++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (upd_pred_state !== 1'b1 || lpt_addr !== e.addr ||
            actual_brch_result !== e.act || mispredict !== e.misp ||
            (e.misp && redirect_pc !== e.pc)) begin
          errs++;
          $display("FAIL match_strobe[%0d]: got upd=%0b addr=%0d act=%0b misp=%0b pc=%h need 1 %0d %0b %0b %h",
                   i, upd_pred_state, lpt_addr, actual_brch_result,
                   mispredict, redirect_pc, e.addr, e.act, e.misp, e.pc);
        end
      end else if (upd_pred_state !== 1'b0 || mispredict !== 1'b0) begin
        errs++;
        $display("FAIL match_idle[%0d]: got upd=%0b misp=%0b need 0 0",
                 i, upd_pred_state, mispredict);
      end
      vec++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == 4) ||
          underflow_err !== munder) begin
        errs++;
        $display("FAIL match_occ[%0d]: got count=%0d full=%0b uf=%0b need %0d %0b %0b",
                 i, count, full, underflow_err, mq.size(), mq.size() == 4, munder);
      end
    end
  endtask

  task automatic test_full_flush();
    stim_t st[$];
    do_reset();
    for (int k = 1; k <= 4; k++)
      st.push_back(mk(1, 5'(k), 1, 32'h1000 + 32'(k * 4), 0, 0, 0));
    st.push_back(mk(1, 5'd9,  1, 32'h9000, 0, 0, 0));
    st.push_back(mk(1, 5'd20, 1, 32'h2000, 1, 0, 32'h0));
    st.push_back(mk(1, 5'd21, 1, 32'h2100, 0, 0, 0));
    st.push_back(mk(1, 5'd6,  0, 32'h3000, 0, 0, 0));
    st.push_back(mk(0, 5'd0,  0, 32'h0,    1, 0, 32'h0));
    st.push_back(mk(0, 5'd0,  0, 32'h0,    0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      vec++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (upd_pred_state !== 1'b1 || lpt_addr !== e.addr ||
            actual_brch_result !== e.act || mispredict !== e.misp ||
            (e.misp && redirect_pc !== e.pc)) begin
          errs++;
          $display("FAIL flush_strobe[%0d]: got upd=%0b addr=%0d act=%0b misp=%0b pc=%h need 1 %0d %0b %0b %h",
                   i, upd_pred_state, lpt_addr, actual_brch_result,
                   mispredict, redirect_pc, e.addr, e.act, e.misp, e.pc);
        end
      end else if (upd_pred_state !== 1'b0 || mispredict !== 1'b0) begin
        errs++;
        $display("FAIL flush_idle[%0d]: got upd=%0b misp=%0b need 0 0",
                 i, upd_pred_state, mispredict);
      end
      vec++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == 4) ||
          underflow_err !== munder) begin
        errs++;
        $display("FAIL flush_occ[%0d]: got count=%0d full=%0b uf=%0b need %0d %0b %0b",
                 i, count, full, underflow_err, mq.size(), mq.size() == 4, munder);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      s = mk(0, 5'd0, 0, 32'h0, 0, 0, 0);
      if (i < 2) s = mk(1, 5'(10 + i), 1'(i), 32'h400 + 32'(i), 0, 0, 0);
      else if (i < 9) begin
        s = mk(1, 5'(5 + i), 1'(i % 2), 32'h500 + 32'(i), 1, 0, 32'h0);
        if (i == 2) s.a = 5'd7;
        if (mq.size() > 0) s.rt = mq[0].taken;
      end else if (i < 11) begin
        s = mk(0, 5'd0, 0, 32'h0, 1, 0, 32'h0);
        if (mq.size() > 0) s.rt = mq[0].taken;
      end
      drive(s);
      vec++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (upd_pred_state !== 1'b1 || lpt_addr !== e.addr ||
            actual_brch_result !== e.act || mispredict !== e.misp ||
            (e.misp && redirect_pc !== e.pc)) begin
          errs++;
          $display("FAIL b2b_strobe[%0d]: got upd=%0b addr=%0d act=%0b misp=%0b pc=%h need 1 %0d %0b %0b %h",
                   i, upd_pred_state, lpt_addr, actual_brch_result,
                   mispredict, redirect_pc, e.addr, e.act, e.misp, e.pc);
        end
      end else if (upd_pred_state !== 1'b0 || mispredict !== 1'b0) begin
        errs++;
        $display("FAIL b2b_idle[%0d]: got upd=%0b misp=%0b need 0 0",
                 i, upd_pred_state, mispredict);
      end
      vec++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == 4) ||
          underflow_err !== munder) begin
        errs++;
        $display("FAIL b2b_occ[%0d]: got count=%0d full=%0b uf=%0b need %0d %0b %0b",
                 i, count, full, underflow_err, mq.size(), mq.size() == 4, munder);
      end
    end
  endtask

  task automatic test_underflow_reset();
    stim_t st[$];
    do_reset();
    st.push_back(mk(0, 5'd0,  0, 32'h0,   1, 1, 32'h40));
    st.push_back(mk(0, 5'd0,  0, 32'h0,   0, 0, 0));
    st.push_back(mk(1, 5'd12, 1, 32'h600, 0, 0, 0));
    st.push_back(mk(1, 5'd13, 0, 32'h604, 0, 0, 0));
    st.push_back(mk(1, 5'd14, 1, 32'h608, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      vec++;
      if (upd_pred_state !== 1'b0 || mispredict !== 1'b0) begin
        errs++;
        $display("FAIL uf_idle[%0d]: got upd=%0b misp=%0b need 0 0",
                 i, upd_pred_state, mispredict);
      end
      vec++;
      if (count !== 3'(mq.size()) || underflow_err !== munder) begin
        errs++;
        $display("FAIL uf_occ[%0d]: got count=%0d uf=%0b need %0d %0b",
                 i, count, underflow_err, mq.size(), munder);
      end
    end
    rst       = 1'b1;
    res_valid = 1'b1;
    res_taken = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_valid = 1'b0;
    mq.delete();
    sb.delete();
    mflush = 1'b0;
    munder = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec++;
      if (count !== 3'(mq.size()) || upd_pred_state !== 1'b0 ||
          mispredict !== 1'b0 || underflow_err !== munder) begin
        errs++;
        $display("FAIL midrst[%0d]: got count=%0d upd=%0b misp=%0b uf=%0b need %0d 0 0 %0b",
                 i, count, upd_pred_state, mispredict, underflow_err,
                 mq.size(), munder);
      end
      drive(mk(0, 5'd0, 0, 32'h0, 0, 0, 0));
    end
  endtask

`ifdef BPQ_STATS_EN
  task automatic test_stats();
    do_reset();
    drive(mk(1, 5'd1, 1, 32'h10, 0, 0, 0));
    drive(mk(1, 5'd2, 0, 32'h14, 1, 1, 32'h0));
    drive(mk(0, 5'd0, 0, 32'h0,  1, 0, 32'h0));
    drive(mk(1, 5'd3, 1, 32'h18, 0, 0, 0));
    drive(mk(0, 5'd0, 0, 32'h0,  1, 0, 32'h77));
    drive(mk(0, 5'd0, 0, 32'h0,  0, 0, 0));
    drive(mk(0, 5'd0, 0, 32'h0,  0, 0, 0));
    sb.delete();
    vec++;
    if (stat_resolved !== 16'(mres) || stat_mispred !== 16'(mmis)) begin
      errs++;
      $display("FAIL stats: got resolved=%0d mispred=%0d need %0d %0d",
               stat_resolved, stat_mispred, mres, mmis);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_full_flush();
    test_back_to_back();
    test_underflow_reset();
`ifdef BPQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
